brent_kung_pipe_adder: RTL and testbench
========================================

Name: brent_kung_pipe_adder

Overview:
- Parametrised, pipelined Brent-Kung parallel-prefix adder with carry-in, carry-out and a valid/ready stream interface.
- Successor to the fixed 16-bit combinational prefix tree. Generalised to WIDTH bits and split into three register stages: operand capture, up-sweep, down-sweep/sum.
- Sits between an operand-producing datapath and a result consumer that may stall.
- Accepts one operation per cycle at full throughput.

Parameters:
- WIDTH, 16, operand width; power of two, 4..64. LOG2W = log2(WIDTH).

Ports:
- clk  input  1  clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept the operand beat this cycle.
- data1  input  WIDTH  operand A.
- data2  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  data1 + data2 + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: asynchronous active-low reset applies immediately when rst_n = 0, regardless of clk. It clears all stage valid bits, so out_valid = 0, sum = 0, cout = 0 and in_ready = 1 once rst_n = 1. Data registers are cleared as well.
- Handshake:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
  - While out_valid = 1 and out_ready = 0, sum and cout hold stable.
- Stage S0, operand capture: registers p = data1^data2, g = data1&data2 and cin. Bit 0 generate is folded as g0' = g0 | (p0 & cin).
- Stage S1, up-sweep: LOG2W levels of black cells at the Brent-Kung up-sweep positions.
  - Black cell combine: (G,P) = (Gh | Ph&Gl, Ph&Pl).
  - Registers the partial (G,P) vectors plus the original p.
- Stage S2, down-sweep and sum: LOG2W-1 levels of gray cells produce group carry Gc[i] for bits i:0.
  - Carry into bit i: c0 = cin, ci = Gc[i-1].
  - sum[i] = p[i] ^ c[i]; cout = Gc[WIDTH-1].
  - S2 output registers drive sum and cout.
- Latency: 3 cycles from input transfer to out_valid, with no stalls. Throughput: 1 result per cycle.
- Flow control is bubble-collapsing, per stage k:
  - adv_k = valid_k ? (downstream accepts) : 1.
  - S2 accepts when it is empty or out_ready = 1.
  - A stage accepts when it is empty or its successor accepts.
  - in_ready = S0 accepts, combinationally.
  - Bubbles are squeezed out under backpressure, so 3 results can be buffered with out_ready held low.
- A held stage keeps both its data and its valid bit. Beats are never dropped or duplicated, and order is preserved.
- Simultaneous events: when S2 is full and out_ready = 1 in the same cycle that an input is accepted, all stages shift together.
- Boundaries:
  - All-ones + all-ones + cin = 1 gives sum all-ones and cout = 1.
  - 0 + 0 + cin = 1 gives sum = 1 and cout = 0.
  - Full carry propagate case: A = all-ones, B = 0, cin = 1 gives sum = 0 and cout = 1.
- Reset mid-operation: in-flight beats are discarded; nothing is emitted after rst_n deasserts until new input arrives.

Optional Feature:
- Macro: BK_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit), registered in S2 and aligned with sum.
  - ovf = Gc[WIDTH-1] ^ Gc[WIDTH-2], i.e. c[WIDTH] ^ c[WIDTH-1] (two's-complement overflow).
  - ovf resets to 0 and holds under stall like sum.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle → out_valid = 0, sum = 0x0000, cout = 0, in_ready = 1; async assert mid-cycle clears out_valid without a clk edge.
- WIDTH=16, single beat 0x1234 + 0x4321, cin = 0 → after 3 cycles sum = 0x5555, cout = 0, out_valid for exactly 1 cycle (out_ready = 1).
- Carry chain beats 0xFFFF + 0x0000, cin = 1, then 0xFFFF + 0xFFFF, cin = 1:
  - first result → sum = 0x0000, cout = 1;
  - second result → sum = 0xFFFF, cout = 1.
  - With BK_OVERFLOW_EN: 0x7FFF + 0x0001 → sum = 0x8000, ovf = 1.
- Back-to-back 100 random beats with out_ready = 1 → one result per cycle, in order, all matching a reference model.
- Backpressure: stream 5 beats, out_ready = 0 from cycle 2 → in_ready drops after 3 beats are buffered; sum is stable while stalled; release gives all 5 results in order, no loss or duplication.
- Parameter sweep WIDTH = 4, 32, 64, random stimulus with random out_ready → results match reference; WIDTH=4 case 0xF + 0x1 gives sum = 0x0, cout = 1.

Source files
------------

// File: rtl/brent_kung_pipe_adder.sv
// brent_kung_pipe_adder: three-stage pipelined Brent-Kung prefix adder with a
// valid/ready stream interface and bubble-collapsing flow control.
//   S0 captures propagate/generate bits, and folds cin into the bit-0 generate.
//   S1 registers the up-sweep (black cells).
//   S2 registers the down-sweep (gray cells) and the final sum and carry out.
// Optional feature: define BK_OVERFLOW_EN to add the registered two's-complement
// overflow output ovf, which is aligned with sum.
module brent_kung_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BK_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int LOG2W = $clog2(WIDTH);

  // Stage-k accept: the stage is empty, or its contents move on this cycle.
  logic acc_p0;
  logic acc_p1;
  logic acc_p2;

  logic             vld_p0;
  logic [WIDTH-1:0] p_p0;
  logic [WIDTH-1:0] g_p0;
  logic             cin_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] gu_p1;
  logic [WIDTH-1:0] pu_p1;
  logic [WIDTH-1:0] p_p1;
  logic             cin_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] sum_p2;
  logic             cout_p2;
`ifdef BK_OVERFLOW_EN
  logic             ovf_p2;
`endif

  logic [WIDTH-1:0] gu;
  logic [WIDTH-1:0] pu;
  logic [WIDTH-1:0] gc;
  logic [WIDTH-1:0] carry;

  // Bubble-collapsing accept chain, evaluated from the output back to the input.
  always_comb begin
    acc_p2 = !vld_p2 || out_ready;
    acc_p1 = !vld_p1 || acc_p2;
    acc_p0 = !vld_p0 || acc_p1;
  end

  assign in_ready  = acc_p0;
  assign out_valid = vld_p2;
  assign sum       = sum_p2;
  assign cout      = cout_p2;
`ifdef BK_OVERFLOW_EN
  assign ovf       = ovf_p2;
`endif

  // ---- S0: operand capture ----
  // Stores p/g. cin is folded into the bit-0 generate, so the prefix tree
  // carries it for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      p_p0   <= '0;
      g_p0   <= '0;
      cin_p0 <= 1'b0;
    end else if (acc_p0) begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        p_p0   <= data1 ^ data2;
        g_p0   <= (data1 & data2) | {{(WIDTH-1){1'b0}}, (data1[0] ^ data2[0]) & cin};
        cin_p0 <= cin;
      end
    end
  end

  // Up-sweep: at level l, each node i = k*2^(l+1)-1 absorbs the span just below it.
  always_comb begin
    gu = g_p0;
    pu = p_p0;
    for (int l = 0; l < LOG2W; l++) begin
      for (int i = (1 << (l + 1)) - 1; i < WIDTH; i += (1 << (l + 1))) begin
        gu[i] = gu[i] | (pu[i] & gu[i - (1 << l)]);
        pu[i] = pu[i] & pu[i - (1 << l)];
      end
    end
  end

  // ---- S1: up-sweep register ----
  // Holds the partial group (G,P) vectors and the raw propagate bits for the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      gu_p1  <= '0;
      pu_p1  <= '0;
      p_p1   <= '0;
      cin_p1 <= 1'b0;
    end else if (acc_p1) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        gu_p1  <= gu;
        pu_p1  <= pu;
        p_p1   <= p_p0;
        cin_p1 <= cin_p0;
      end
    end
  end

  // Down-sweep: gray cells fill in the remaining prefixes. Coarse levels run first.
  always_comb begin
    gc = gu_p1;
    for (int l = LOG2W - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (1 << (l + 1))) begin
        gc[i] = gc[i] | (pu_p1[i] & gc[i - (1 << l)]);
      end
    end
    carry = {gc[WIDTH-2:0], cin_p1};
  end

  // ---- S2: sum/carry output register ----
  // Holds its value while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
`ifdef BK_OVERFLOW_EN
      ovf_p2  <= 1'b0;
`endif
    end else if (acc_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sum_p2  <= p_p1 ^ carry;
        cout_p2 <= gc[WIDTH-1];
`ifdef BK_OVERFLOW_EN
        ovf_p2  <= gc[WIDTH-1] ^ gc[WIDTH-2];
`endif
      end
    end
  end

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// Bench for brent_kung_pipe_adder. Lane 0 is WIDTH=16 and carries the directed tests.
// Lanes 1-3 (WIDTH 4/32/64) run random streams under random backpressure.
// A reference model checks every lane on every cycle. Its behaviour is derived
// from plain integer addition and from pipeline occupancy.
module tb_brent_kung_pipe_adder;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    longint      t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [3:0]  ci;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  cout_s;
`ifdef BK_OVERFLOW_EN
  logic [3:0]  ovf_s;
`endif
  logic [63:0] a_s   [4];
  logic [63:0] b_s   [4];
  logic [63:0] sum_s [4];

  exp_t   q [4][$];
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam int W = (k == 0) ? 16 : (k == 1) ? 4 : (k == 2) ? 32 : 64;
    logic [W-1:0] s_loc;
    brent_kung_pipe_adder #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv[k]),
      .in_ready (ir[k]),
      .data1    (a_s[k][W-1:0]),
      .data2    (b_s[k][W-1:0]),
      .cin      (ci[k]),
      .out_valid(ov[k]),
      .out_ready(ordy[k]),
      .sum      (s_loc),
      .cout     (cout_s[k])
`ifdef BK_OVERFLOW_EN
      ,
      .ovf      (ovf_s[k])
`endif
    );
    assign sum_s[k] = 64'(s_loc);
  end

  function automatic int wof(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : (k == 2) ? 32 : 64;
  endfunction

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference result from plain integer addition.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic c);
    exp_t        r;
    logic [64:0] f;
    logic [63:0] am;
    logic [63:0] bm;
    am  = a & mask(w);
    bm  = b & mask(w);
    f   = {1'b0, am} + {1'b0, bm} + {64'd0, c};
    r.s = f[63:0] & mask(w);
    r.c = f[w];
    r.o = (am[w-1] == bm[w-1]) && (r.s[w-1] != am[w-1]);
    r.t = 0;
    return r;
  endfunction

  task automatic chk(input string name, input int lane, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, lane, got, exp, cyc);
    end
  endtask

  // Expected out_valid: the oldest beat has spent three edges in the pipe.
  // Expected in_ready: fewer than three beats are held, or the consumer takes one.
  task automatic check_lane(input int k);
    int   w;
    logic exp_ov;
    logic exp_ir;
    exp_t e;
    w      = wof(k);
    exp_ov = 1'b0;
    if (q[k].size() > 0) exp_ov = (cyc - q[k][0].t) >= 2;
    chk("out_valid", k, ov[k], exp_ov);
    exp_ir = (q[k].size() < 3) || ordy[k];
    chk("in_ready", k, ir[k], exp_ir);
    if (ov[k] && q[k].size() > 0) begin
      e = q[k][0];
      chk("sum", k, sum_s[k], e.s);
      chk("cout", k, cout_s[k], e.c);
`ifdef BK_OVERFLOW_EN
      chk("ovf", k, ovf_s[k], e.o);
`endif
      if (ordy[k]) void'(q[k].pop_front());
    end
    if (iv[k] && ir[k]) begin
      e   = model(w, a_s[k], b_s[k], ci[k]);
      e.t = cyc + 1;
      q[k].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) check_lane(k);
    end
  end

  task automatic send(input int k, input logic [63:0] a, input logic [63:0] b, input logic c);
    logic took;
    int   guard;
    a_s[k] = a;
    b_s[k] = b;
    ci[k]  = c;
    iv[k]  = 1'b1;
    took   = 1'b0;
    guard  = 0;
    while (!took && guard <= 50) begin
      @(negedge clk);
      took = ir[k];
      @(posedge clk);
      #1;
      guard++;
    end
    iv[k] = 1'b0;
    chk("send_accept", k, took, 1);
  endtask

  task automatic run_lane(input int k);
    repeat (400) begin
      @(posedge clk);
      #1;
      iv[k]   = ($urandom_range(0, 3) != 0);
      a_s[k]  = {$urandom, $urandom};
      b_s[k]  = {$urandom, $urandom};
      ci[k]   = 1'($urandom_range(0, 1));
      ordy[k] = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk);
    #1;
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("sweep_drain", k, 64'(q[k].size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '1;
    ci    = '0;
    for (int k = 0; k < 4; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 0, ov[0], 0);
    chk("rst_sum", 0, sum_s[0], 0);
    chk("rst_cout", 0, cout_s[0], 0);
    chk("rst_in_ready", 0, ir[0], 1);

    // Single beat, three-cycle latency, one-cycle valid.
    send(0, 64'h1234, 64'h4321, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("single_valid", 0, ov[0], 1);
    chk("single_sum", 0, sum_s[0], 64'h5555);
    chk("single_cout", 0, cout_s[0], 0);
    @(posedge clk);
    #1;
    chk("single_valid_drop", 0, ov[0], 0);

    // Carry-chain boundaries, sent back to back.
    send(0, 64'hFFFF, 64'h0000, 1'b1);
    send(0, 64'hFFFF, 64'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    chk("prop_sum", 0, sum_s[0], 64'h0000);
    chk("prop_cout", 0, cout_s[0], 1);
    @(posedge clk);
    #1;
    chk("ones_sum", 0, sum_s[0], 64'hFFFF);
    chk("ones_cout", 0, cout_s[0], 1);

    send(0, 64'h0000, 64'h0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("zero_cin_sum", 0, sum_s[0], 64'h0001);
    chk("zero_cin_cout", 0, cout_s[0], 0);

    send(0, 64'h7FFF, 64'h0001, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_case_sum", 0, sum_s[0], 64'h8000);
    chk("ovf_case_cout", 0, cout_s[0], 0);
`ifdef BK_OVERFLOW_EN
    chk("ovf_case_ovf", 0, ovf_s[0], 1);
`endif

    // 100 random beats back to back at full throughput.
    for (int i = 0; i < 100; i++) begin
      send(0, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(posedge clk);
    #1;
    chk("rand_drain", 0, 64'(q[0].size()), 0);

    // Backpressure: three beats fill the pipe, the rest wait for release.
    ordy[0] = 1'b0;
    send(0, 64'h0001, 64'h0001, 1'b0);
    send(0, 64'h0002, 64'h0002, 1'b0);
    send(0, 64'h0003, 64'h0003, 1'b0);
    chk("bp_full_in_ready", 0, ir[0], 0);
    chk("bp_full_valid", 0, ov[0], 1);
    chk("bp_full_sum", 0, sum_s[0], 64'h0002);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_hold_sum", 0, sum_s[0], 64'h0002);
    chk("bp_hold_in_ready", 0, ir[0], 0);
    fork
      begin
        send(0, 64'h0004, 64'h0004, 1'b0);
        send(0, 64'h0005, 64'h0005, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 ordy[0] = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("bp_drain", 0, 64'(q[0].size()), 0);

    // Reset mid-operation: an asynchronous clear with no clock edge.
    send(0, 64'h0010, 64'h0020, 1'b0);
    send(0, 64'h0100, 64'h0200, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 0, ov[0], 1);
    chk("pre_rst_sum", 0, sum_s[0], 64'h0030);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, ov[0], 0);
    chk("async_rst_sum", 0, sum_s[0], 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_valid", 0, ov[0], 0);
    chk("post_rst_in_ready", 0, ir[0], 1);

    // Width sweep: the WIDTH=4 wrap case, then random traffic on lanes 1-3.
    send(1, 64'hF, 64'h1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("w4_sum", 1, sum_s[1], 64'h0);
    chk("w4_cout", 1, cout_s[1], 1);
    fork
      run_lane(1);
      run_lane(2);
      run_lane(3);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
